// File: rtl/y86_mem_pkg.sv
// Shared types and default constants for the Y86 unified-memory port arbiter,
// its memory model and bench.
package y86_mem_pkg;

   localparam int unsigned DEF_ADDR_W       = 64;
   localparam int unsigned DEF_DATA_W       = 64;
   localparam int unsigned DEF_TIMEOUT_CYC  = 16;
   localparam int unsigned DEF_MAX_D_STREAK = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational I/D priority picker: D wins unless I has been starved for a
// full streak.
module mem_arb_pick (
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic streak_sat_i,
   output logic grant_d_c,
   output logic grant_i_c
);

   assign grant_d_c = d_req_i & ~(i_req_i & streak_sat_i);
   assign grant_i_c = i_req_i & ~grant_d_c;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between the fetch (I) and
// memory-stage (D) ports, one transaction at a time, with timeout and flush.
module mem_port_arbiter
   import y86_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
   parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   input  logic              i_flush_i,
   output logic [DATA_W-1:0] i_rdata_o,
   output logic              i_ready_o,
   output logic              i_err_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              d_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_abort_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i
);

   localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYC);
   localparam int unsigned     STRK_W   = $clog2(MAX_D_STREAK + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_D_STREAK);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [STRK_W-1:0]   streak_q, streak_d;
   logic                flushed_q, flushed_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_abort_q, mem_abort_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic                i_ready_q, i_ready_d;
   logic                i_err_q, i_err_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                d_ready_q, d_ready_d;
   logic                d_err_q, d_err_d;

   logic                grant_d, grant_i, streak_sat;
   logic                drop_i;
   logic [DATA_W-1:0]   rsp_data;

   assign streak_sat = (streak_q == STRK_MAX);

   mem_arb_pick u_pick (
      .i_req_i      (i_req_i),
      .d_req_i      (d_req_i),
      .streak_sat_i (streak_sat),
      .grant_d_c    (grant_d),
      .grant_i_c    (grant_i)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      timer_d     = timer_q;
      streak_d    = streak_q;
      flushed_d   = flushed_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_abort_d = 1'b0;
      i_rdata_d   = i_rdata_q;
      i_ready_d   = 1'b0;
      i_err_d     = 1'b0;
      d_rdata_d   = d_rdata_q;
      d_ready_d   = 1'b0;
      d_err_d     = 1'b0;
      // A flush landing on the completing edge also discards the response
      drop_i      = (owner_q == OWN_I) && (flushed_q || i_flush_i);
      rsp_data    = mem_we_q ? '0 : mem_rdata_i;

      case (state_q)
         IDLE: begin
            timer_d   = '0;
            flushed_d = 1'b0;
            if (!i_req_i || grant_i) begin
               streak_d = '0;
            end else if (grant_d && !streak_sat) begin
               streak_d = streak_q + STRK_W'(1);
            end
            if (grant_d) begin
               owner_d     = OWN_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we_i;
               mem_addr_d  = d_addr_i;
               mem_wdata_d = d_wdata_i;
               state_d     = WAIT;
            end else if (grant_i) begin
               owner_d     = OWN_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_addr_i;
               mem_wdata_d = '0;
               state_d     = WAIT;
            end
         end

         WAIT: begin
            if (i_flush_i && owner_q == OWN_I) begin
               flushed_d = 1'b1;
            end
            if (mem_ready_i) begin
               if (owner_q == OWN_D) begin
                  d_ready_d = 1'b1;
                  d_rdata_d = rsp_data;
               end else if (!drop_i) begin
                  i_ready_d = 1'b1;
                  i_rdata_d = rsp_data;
               end
               state_d = RESP;
            end else if (timer_q == TMR_LAST) begin
               mem_abort_d = 1'b1;
               if (owner_q == OWN_D) begin
                  d_ready_d = 1'b1;
                  d_err_d   = 1'b1;
                  d_rdata_d = '0;
               end else if (!drop_i) begin
                  i_ready_d = 1'b1;
                  i_err_d   = 1'b1;
                  i_rdata_d = '0;
               end
               state_d = RESP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         RESP: begin
            flushed_d = 1'b0;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         timer_q     <= '0;
         streak_q    <= '0;
         flushed_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_abort_q <= 1'b0;
         i_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         i_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         d_ready_q   <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         timer_q     <= timer_d;
         streak_q    <= streak_d;
         flushed_q   <= flushed_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_abort_q <= mem_abort_d;
         i_rdata_q   <= i_rdata_d;
         i_ready_q   <= i_ready_d;
         i_err_q     <= i_err_d;
         d_rdata_q   <= d_rdata_d;
         d_ready_q   <= d_ready_d;
         d_err_q     <= d_err_d;
      end
   end

   assign i_rdata_o   = i_rdata_q;
   assign i_ready_o   = i_ready_q;
   assign i_err_o     = i_err_q;
   assign d_rdata_o   = d_rdata_q;
   assign d_ready_o   = d_ready_q;
   assign d_err_o     = d_err_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_abort_o = mem_abort_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-programmable memory model
// answers strobes, a monitor pops expected responses on every ready pulse.
module tb_mem_port_arbiter;
   import y86_mem_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        i_req_i, i_flush_i, d_req_i, d_we_i;
   logic [63:0] i_addr_i, d_addr_i, d_wdata_i;
   logic [63:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        i_ready_o, i_err_o, d_ready_o, d_err_o;
   logic        mem_req_o, mem_we_o, mem_abort_o, mem_ready_i;

   mem_port_arbiter dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
      .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o), .i_err_o(i_err_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o), .d_err_o(d_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_abort_o(mem_abort_o),
      .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        d;
      logic        err;
      logic        abort;
      logic [63:0] rdata;
      logic [31:0] dly;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_resp   = 0;
   int          cyc      = 0;
   int          cyc_req  = 0;

   // memory model state
   int          mdl_lat = 1;
   int          mdl_cnt = 0;
   logic        mdl_ready = 1'b0;
   logic [63:0] mdl_rdata = '0;
   logic [63:0] mdl_addr  = '0;
   logic        frc_ready = 1'b0;
   logic [63:0] frc_rdata = '0;
   int          req_cnt   = 0;
   logic        last_we   = 1'b0;
   logic [63:0] last_addr = '0;
   logic [63:0] last_wdata = '0;

   assign mem_ready_i = mdl_ready | frc_ready;
   assign mem_rdata_i = frc_ready ? frc_rdata : mdl_rdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_val(input logic [63:0] a);
      if (a == 64'h100) return 64'hDEADBEEF;
      return {a[31:0], ~a[31:0]};
   endfunction

   function automatic void push(input logic d, input logic err, input logic abort,
                                input logic [63:0] rdata, input int dly);
      exp_t e;
      e.d = d; e.err = err; e.abort = abort; e.rdata = rdata; e.dly = 32'(dly);
      sb.push_back(e);
   endfunction

   // Registered memory: sees the strobe at the next edge, answers mdl_lat cycles on
   always begin
      @(posedge clk_i);
      #1;
      mdl_ready = 1'b0;
      if (mem_abort_o) mdl_cnt = 0;
      if (mdl_cnt > 0) begin
         mdl_cnt--;
         if (mdl_cnt == 0) begin
            mdl_ready = 1'b1;
            mdl_rdata = mem_val(mdl_addr);
         end
      end
      if (mem_req_o) begin
         mdl_cnt    = mdl_lat;
         mdl_addr   = mem_addr_o;
         req_cnt++;
         last_we    = mem_we_o;
         last_addr  = mem_addr_o;
         last_wdata = mem_wdata_o;
      end
   end

   always begin
      @(posedge clk_i);
      cyc++;
      #2;
      if (mem_req_o) cyc_req = cyc;
      if (i_ready_o || d_ready_o) begin
         n_resp++;
         if (sb.size() == 0) begin
            chk("unexpected_ready", {62'd0, d_ready_o, i_ready_o}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("port", {62'd0, d_ready_o, i_ready_o}, e.d ? 64'd2 : 64'd1);
            chk("err", {63'd0, e.d ? d_err_o : i_err_o}, {63'd0, e.err});
            chk("rdata", e.d ? d_rdata_o : i_rdata_o, e.rdata);
            chk("abort", {63'd0, mem_abort_o}, {63'd0, e.abort});
            chk("latency", 64'(cyc - cyc_req), 64'(e.dly));
         end
      end
   end

   task automatic wait_resp(input int target, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(posedge clk_i); #3;
         if (n_resp >= target) break;
      end
      if (k == budget) chk("resp_timeout", 64'(n_resp), 64'(target));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk_i); #3; end
   endtask

   task automatic d_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
      d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_req_i = 1'b1;
      wait_resp(n_resp + 1, 40);
      d_req_i = 1'b0;
   endtask

   task automatic i_txn(input logic [63:0] addr);
      i_addr_i = addr; i_req_i = 1'b1;
      wait_resp(n_resp + 1, 40);
      i_req_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:9]  ord;
      int          ed, ei, dn, inn, base, k, rc;

      rst_n_i = 1'b0; i_req_i = 1'b0; i_flush_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
      i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
      #3;
      chk("reset_ctl", {57'd0, i_ready_o, i_err_o, d_ready_o, d_err_o, mem_req_o, mem_we_o, mem_abort_o}, 64'd0);
      chk("reset_data", i_rdata_o | d_rdata_o | mem_addr_o | mem_wdata_o, 64'd0);
      idle_cycles(2);
      rst_n_i = 1'b1;
      idle_cycles(2);

      // Single D read, memory latency 3
      mdl_lat = 3; rc = req_cnt;
      push(1'b1, 1'b0, 1'b0, 64'hDEADBEEF, 4);
      d_txn(1'b0, 64'h100, 64'h0);
      idle_cycles(2);
      chk("t1_req_count", 64'(req_cnt - rc), 64'd1);
      chk("t1_req_addr", last_addr, 64'h100);
      chk("t1_req_we", {63'd0, last_we}, 64'd0);

      // Both ports held: streak of four D grants, then I
      mdl_lat = 1; ord = 10'b1111011110; ed = 0; ei = 0;
      for (int j = 0; j < 10; j++) begin
         if (ord[j]) begin push(1'b1, 1'b0, 1'b0, mem_val(64'h1000 + 64'(8 * ed)), 2); ed++; end
         else        begin push(1'b0, 1'b0, 1'b0, mem_val(64'h2000 + 64'(8 * ei)), 2); ei++; end
      end
      dn = 0; inn = 0; base = n_resp;
      d_we_i = 1'b0; d_addr_i = 64'h1000; i_addr_i = 64'h2000;
      d_req_i = 1'b1; i_req_i = 1'b1;
      for (k = 0; k < 200; k++) begin
         @(posedge clk_i); #3;
         if (d_ready_o) begin dn++; d_addr_i = 64'h1000 + 64'(8 * dn); end
         if (i_ready_o) begin inn++; i_addr_i = 64'h2000 + 64'(8 * inn); end
         if (n_resp - base >= 10) break;
      end
      d_req_i = 1'b0; i_req_i = 1'b0;
      chk("t2_done", 64'(n_resp - base), 64'd10);
      idle_cycles(2);

      // D write that times out
      mdl_lat = 0;
      push(1'b1, 1'b1, 1'b1, 64'h0, 16);
      d_txn(1'b1, 64'h40, 64'h55);
      chk("t3_req_we", {63'd0, last_we}, 64'd1);
      chk("t3_req_wdata", last_wdata, 64'h55);
      mdl_lat = 1;
      push(1'b1, 1'b0, 1'b0, mem_val(64'h48), 2);
      d_txn(1'b0, 64'h48, 64'h0);
      idle_cycles(1);

      // Flushed I read: no response, then a clean one
      mdl_lat = 3; base = n_resp;
      i_addr_i = 64'h500; i_req_i = 1'b1;
      for (k = 0; k < 10; k++) begin
         @(posedge clk_i); #3;
         if (mem_req_o) break;
      end
      chk("t4_issue", {63'd0, mem_req_o}, 64'd1);
      @(posedge clk_i); #3;
      i_flush_i = 1'b1; i_req_i = 1'b0;
      @(posedge clk_i); #3;
      i_flush_i = 1'b0;
      idle_cycles(8);
      chk("t4_flush_noresp", 64'(n_resp - base), 64'd0);
      mdl_lat = 1;
      push(1'b0, 1'b0, 1'b0, mem_val(64'h508), 2);
      i_txn(64'h508);
      idle_cycles(1);

      // Reset mid-WAIT with memory ready during reset
      mdl_lat = 0; base = n_resp;
      d_we_i = 1'b0; d_addr_i = 64'h300; d_req_i = 1'b1;
      for (k = 0; k < 10; k++) begin
         @(posedge clk_i); #3;
         if (mem_req_o) break;
      end
      @(posedge clk_i); #3;
      chk("t5_pre_addr", mem_addr_o, 64'h300);
      rst_n_i = 1'b0; d_req_i = 1'b0; frc_rdata = 64'h1234; frc_ready = 1'b1;
      #1;
      chk("t5_rst_ctl", {57'd0, i_ready_o, i_err_o, d_ready_o, d_err_o, mem_req_o, mem_we_o, mem_abort_o}, 64'd0);
      chk("t5_rst_data", i_rdata_o | d_rdata_o | mem_addr_o | mem_wdata_o, 64'd0);
      @(posedge clk_i); #3;
      frc_ready = 1'b0; rst_n_i = 1'b1;
      idle_cycles(3);
      chk("t5_no_resp", 64'(n_resp - base), 64'd0);
      mdl_lat = 1;
      push(1'b1, 1'b0, 1'b0, mem_val(64'h308), 2);
      d_txn(1'b0, 64'h308, 64'h0);
      idle_cycles(1);

      // Spurious mem_ready_i in IDLE and in RESP
      base = n_resp; rc = req_cnt;
      frc_rdata = 64'hBAD; frc_ready = 1'b1;
      @(posedge clk_i); #3;
      frc_ready = 1'b0;
      idle_cycles(2);
      chk("t6_idle_noresp", 64'(n_resp - base), 64'd0);
      chk("t6_idle_noreq", 64'(req_cnt - rc), 64'd0);
      push(1'b1, 1'b0, 1'b0, 64'h0, 2);
      d_we_i = 1'b1; d_addr_i = 64'h700; d_wdata_i = 64'h77; d_req_i = 1'b1;
      wait_resp(base + 1, 40);
      d_req_i = 1'b0; frc_ready = 1'b1;
      @(posedge clk_i); #3;
      frc_ready = 1'b0;
      idle_cycles(3);
      chk("t6_resp_noresp", 64'(n_resp - base), 64'd1);
      push(1'b0, 1'b0, 1'b0, mem_val(64'h710), 2);
      i_txn(64'h710);
      idle_cycles(2);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
